// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Purpose:
//   Turns raw, bouncing, asynchronous push-button levels from the board into
//   clean single-cycle command pulses for the alarm-clock mode/adjust FSM.
//   Each button has its own fully independent pipeline:
//     raw pin -> 2-FF synchronizer -> sample-based debouncer -> edge detect
//             -> auto-repeat FSM (IDLE / HOLD / REPEAT)
//   Debounce and repeat timing advance only on i_sample_en strobes from the
//   clock divider. Synchronizers and the edge/pulse registers run every clk,
//   so every pulse output is exactly one clk wide.
//
// Ports:
//   clk              system clock (shared with the display driver)
//   rst              synchronous, active-high reset
//   i_sample_en      one-clk debounce/repeat sample strobe (may be held high)
//   i_btn_raw[N]     asynchronous raw button levels, active-high
//   o_btn_level[N]   debounced button level
//   o_btn_press[N]   one-clk pulse on the debounced rising edge
//   o_btn_release[N] one-clk pulse on the debounced falling edge
//   o_btn_repeat[N]  one-clk auto-repeat pulse while a button is held
//   o_any_press      OR of the press pulses, aligned with o_btn_press
//   o_dbg_rpt_state  repeat FSM state, 2 bits per button
//                    ([2*i+1:2*i] = button i; 0 IDLE, 1 HOLD, 2 REPEAT)
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int             N              = 5,
  parameter int             STABLE_SAMPLES = 4,
  parameter int             HOLD_SAMPLES   = 8,
  parameter int             REPEAT_SAMPLES = 3,
  parameter logic [N-1:0]   REPEAT_MASK    = N'(5'b11110)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_sample_en,
  input  logic [N-1:0]     i_btn_raw,
  output logic [N-1:0]     o_btn_level,
  output logic [N-1:0]     o_btn_press,
  output logic [N-1:0]     o_btn_release,
  output logic [N-1:0]     o_btn_repeat,
  output logic             o_any_press,
  output logic [2*N-1:0]   o_dbg_rpt_state
);

  // ---------------------------------------------------------------------------
  // Derived widths and constants
  // ---------------------------------------------------------------------------
  localparam int DB_W   = $clog2(STABLE_SAMPLES + 1);
  localparam int RP_MAX = (HOLD_SAMPLES > REPEAT_SAMPLES) ? HOLD_SAMPLES
                                                          : REPEAT_SAMPLES;
  localparam int RP_W   = $clog2(RP_MAX + 1);

  // Terminal counts: the counter value seen on the sample that completes
  // the interval (the count itself is one behind the sample number).
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(STABLE_SAMPLES - 1);
  localparam logic [RP_W-1:0] HOLD_LAST = RP_W'(HOLD_SAMPLES - 1);
  localparam logic [RP_W-1:0] RPT_LAST  = RP_W'(REPEAT_SAMPLES - 1);

  // Repeat FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer for the asynchronous pins
  // ---------------------------------------------------------------------------
  logic [N-1:0] r_sync1;
  logic [N-1:0] r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Combinational rising-edge flags of all buttons, used for o_any_press
  logic [N-1:0] w_rise;

  // ---------------------------------------------------------------------------
  // Per-button debounce, edge detect and auto-repeat
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < N; gi++) begin : g_btn

    logic            r_level;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_press;
    logic            r_release;
    logic            r_repeat;
    logic [1:0]      r_state;
    logic [RP_W-1:0] r_rp_cnt;

    logic            w_level_next;
    logic [DB_W-1:0] w_db_cnt_next;
    logic            w_rise_b;
    logic            w_fall_b;
    logic [1:0]      w_state_next;
    logic [RP_W-1:0] w_rp_cnt_next;
    logic            w_repeat_next;

    // Debounce: the level only moves after STABLE_SAMPLES consecutive
    // samples that disagree with it; any agreeing sample restarts the count.
    always_comb begin
      w_level_next  = r_level;
      w_db_cnt_next = r_db_cnt;
      if (i_sample_en) begin
        if (r_sync2[gi] == r_level) begin
          w_db_cnt_next = '0;
        end else if (r_db_cnt == DB_LAST) begin
          w_level_next  = ~r_level;
          w_db_cnt_next = '0;
        end else begin
          w_db_cnt_next = r_db_cnt + 1'b1;
        end
      end
    end

    // Edges are taken from the next debounced level so the pulse registers
    // update on the same edge as the level register.
    assign w_rise_b   = w_level_next & ~r_level;
    assign w_fall_b   = ~w_level_next & r_level;
    assign w_rise[gi] = w_rise_b;

    // Auto-repeat FSM. A falling level has priority over everything, so a
    // release that lands on a due repeat sample suppresses that repeat.
    // The press sample moves IDLE->HOLD without being counted. Press and
    // repeat cannot coincide: a press only happens in IDLE, a repeat never.
    always_comb begin
      w_state_next  = r_state;
      w_rp_cnt_next = r_rp_cnt;
      w_repeat_next = 1'b0;
      if (w_fall_b) begin
        w_state_next  = ST_IDLE;
        w_rp_cnt_next = '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_rise_b && REPEAT_MASK[gi]) begin
              w_state_next  = ST_HOLD;
              w_rp_cnt_next = '0;
            end
          end
          ST_HOLD: begin
            if (i_sample_en && r_level) begin
              if (r_rp_cnt == HOLD_LAST) begin
                w_repeat_next = 1'b1;
                w_rp_cnt_next = '0;
                w_state_next  = ST_REPEAT;
              end else begin
                w_rp_cnt_next = r_rp_cnt + 1'b1;
              end
            end
          end
          ST_REPEAT: begin
            if (i_sample_en && r_level) begin
              if (r_rp_cnt == RPT_LAST) begin
                w_repeat_next = 1'b1;
                w_rp_cnt_next = '0;
              end else begin
                w_rp_cnt_next = r_rp_cnt + 1'b1;
              end
            end
          end
          default: begin
            w_state_next  = ST_IDLE;
            w_rp_cnt_next = '0;
          end
        endcase
      end
    end

    // Reset wins over everything, including a pending release: all pulse
    // registers clear and the FSM returns to IDLE in the same edge.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_level   <= 1'b0;
        r_db_cnt  <= '0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_repeat  <= 1'b0;
        r_state   <= ST_IDLE;
        r_rp_cnt  <= '0;
      end else begin
        r_level   <= w_level_next;
        r_db_cnt  <= w_db_cnt_next;
        r_press   <= w_rise_b;
        r_release <= w_fall_b;
        r_repeat  <= w_repeat_next;
        r_state   <= w_state_next;
        r_rp_cnt  <= w_rp_cnt_next;
      end
    end

    assign o_btn_level[gi]             = r_level;
    assign o_btn_press[gi]             = r_press;
    assign o_btn_release[gi]           = r_release;
    assign o_btn_repeat[gi]            = r_repeat;
    assign o_dbg_rpt_state[2*gi +: 2]  = r_state;

  end : g_btn

  // ---------------------------------------------------------------------------
  // Aggregate press flag, registered alongside the per-button press pulses
  // ---------------------------------------------------------------------------
  logic r_any_press;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_any_press <= 1'b0;
    end else begin
      r_any_press <= |w_rise;
    end
  end

  assign o_any_press = r_any_press;

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Directed bench for button_conditioner (default parameters: N=5,
// STABLE_SAMPLES=4, HOLD_SAMPLES=8, REPEAT_SAMPLES=3, REPEAT_MASK=5'b11110).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Latency from a raw change to the debounced level is 2 clk (synchronizer)
// plus 4 samples.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst;
  logic       sample_en;
  logic [4:0] btn_raw;
  logic [4:0] btn_level;
  logic [4:0] btn_press;
  logic [4:0] btn_release;
  logic [4:0] btn_repeat;
  logic       any_press;
  logic [9:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  button_conditioner dut (
    .clk             (clk),
    .rst             (rst),
    .i_sample_en     (sample_en),
    .i_btn_raw       (btn_raw),
    .o_btn_level     (btn_level),
    .o_btn_press     (btn_press),
    .o_btn_release   (btn_release),
    .o_btn_repeat    (btn_repeat),
    .o_any_press     (any_press),
    .o_dbg_rpt_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Driver / checker tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [4:0] lvl,
                           input logic [4:0] prs, input logic [4:0] rel,
                           input logic [4:0] rpt, input logic any);
    check({tag, ".level"},   32'(btn_level),   32'(lvl));
    check({tag, ".press"},   32'(btn_press),   32'(prs));
    check({tag, ".release"}, 32'(btn_release), 32'(rel));
    check({tag, ".repeat"},  32'(btn_repeat),  32'(rpt));
    check({tag, ".any"},     32'(any_press),   32'(any));
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [4:0] bounce_seq [5];
    logic [4:0] e_lvl;
    logic [4:0] e_prs;
    logic [4:0] e_rel;
    logic [4:0] e_rpt;
    logic       e_any;

    // ---- reset ----
    rst       = 1'b1;
    sample_en = 1'b0;
    btn_raw   = 5'b00000;
    repeat (3) tick();
    check_out("reset", 5'b0, 5'b0, 5'b0, 5'b0, 1'b0);
    check("reset.state", 32'(dbg_state), 32'h0);
    rst       = 1'b0;
    sample_en = 1'b1;
    repeat (4) tick();
    check_out("idle", 5'b0, 5'b0, 5'b0, 5'b0, 1'b0);

    // ---- clean press on button 1, then auto-repeat and release ----
    btn_raw = 5'b00010;
    for (int j = 1; j <= 5; j++) begin
      tick();
      check_out("t1.wait", 5'b0, 5'b0, 5'b0, 5'b0, 1'b0);
    end
    tick();
    check_out("t1.press", 5'b00010, 5'b00010, 5'b0, 5'b0, 1'b1);
    check("t1.state_hold", 32'(dbg_state), 32'h004);
    // j counts samples after the press sample. Raw drops after j=29, so the
    // level falls at j=35, which is also a due repeat slot (35-8 = 27).
    for (int j = 1; j <= 40; j++) begin
      tick();
      e_lvl = (j < 35) ? 5'b00010 : 5'b00000;
      e_rel = (j == 35) ? 5'b00010 : 5'b00000;
      e_rpt = (j >= 8 && j < 35 && ((j - 8) % 3) == 0) ? 5'b00010 : 5'b00000;
      check_out("t3.hold", e_lvl, 5'b0, e_rel, e_rpt, 1'b0);
      if (j == 29) btn_raw = 5'b00000;
    end
    check("t3.state_idle", 32'(dbg_state), 32'h0);

    // ---- bouncing press on button 2 ----
    bounce_seq[0] = 5'b00100;
    bounce_seq[1] = 5'b00000;
    bounce_seq[2] = 5'b00100;
    bounce_seq[3] = 5'b00100;
    bounce_seq[4] = 5'b00000;
    for (int k = 0; k < 5; k++) begin
      btn_raw = bounce_seq[k];
      tick();
      check_out("t2.bounce", 5'b0, 5'b0, 5'b0, 5'b0, 1'b0);
    end
    btn_raw = 5'b00100;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_out("t2.settle", 5'b0, 5'b0, 5'b0, 5'b0, 1'b0);
    end
    tick();
    check_out("t2.press", 5'b00100, 5'b00100, 5'b0, 5'b0, 1'b1);
    tick();
    check_out("t2.after", 5'b00100, 5'b0, 5'b0, 5'b0, 1'b0);
    btn_raw = 5'b00000;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_out("t2.rel_wait", 5'b00100, 5'b0, 5'b0, 5'b0, 1'b0);
    end
    tick();
    check_out("t2.release", 5'b0, 5'b0, 5'b00100, 5'b0, 1'b0);
    tick();
    check_out("t2.quiet", 5'b0, 5'b0, 5'b0, 5'b0, 1'b0);

    // ---- masked button 0 held 30 samples ----
    btn_raw = 5'b00001;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_out("t4.wait", 5'b0, 5'b0, 5'b0, 5'b0, 1'b0);
    end
    tick();
    check_out("t4.press", 5'b00001, 5'b00001, 5'b0, 5'b0, 1'b1);
    check("t4.state_idle", 32'(dbg_state), 32'h0);
    for (int j = 1; j <= 30; j++) begin
      tick();
      check_out("t4.hold", 5'b00001, 5'b0, 5'b0, 5'b0, 1'b0);
    end
    btn_raw = 5'b00000;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_out("t4.rel_wait", 5'b00001, 5'b0, 5'b0, 5'b0, 1'b0);
    end
    tick();
    check_out("t4.release", 5'b0, 5'b0, 5'b00001, 5'b0, 1'b0);

    // ---- simultaneous buttons 1 and 3, sample_en every 4 clk ----
    // Raw set before edge 1; sync valid by edge 2; samples at edges 4,8,12,16
    // give the press at 16; repeats 8 samples later (48), then every 12 clk.
    btn_raw = 5'b01010;
    for (int c = 1; c <= 80; c++) begin
      sample_en = ((c % 4) == 0);
      tick();
      e_lvl = (c >= 16) ? 5'b01010 : 5'b00000;
      e_prs = (c == 16) ? 5'b01010 : 5'b00000;
      e_any = (c == 16);
      e_rpt = (c == 48 || c == 60 || c == 72) ? 5'b01010 : 5'b00000;
      check_out("t5.dual", e_lvl, e_prs, 5'b0, e_rpt, e_any);
    end
    check("t5.state_repeat", 32'(dbg_state), 32'h088);

    // ---- reset while in REPEAT, raw still held ----
    rst       = 1'b1;
    sample_en = 1'b0;
    tick();
    check_out("t6.reset", 5'b0, 5'b0, 5'b0, 5'b0, 1'b0);
    check("t6.state_idle", 32'(dbg_state), 32'h0);
    rst       = 1'b0;
    sample_en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_out("t6.wait", 5'b0, 5'b0, 5'b0, 5'b0, 1'b0);
    end
    tick();
    check_out("t6.repress", 5'b01010, 5'b01010, 5'b0, 5'b0, 1'b1);
    check("t6.state_hold", 32'(dbg_state), 32'h044);
    tick();
    check_out("t6.after", 5'b01010, 5'b0, 5'b0, 5'b0, 1'b0);

    // ---- report ----
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
